// File: rtl/vreg_lane_reader_if.sv
// Bundle between the lane reader, the register bank read port and the
// vector ALU input stage.
//   start/reg_sel/busy : command side
//   rd_reg/rd_lane     : read address to bank; rd_data returns combinationally
//   out_*              : valid/ready lane stream towards the execution lanes
//   done               : one-cycle completion pulse
// Modport master is the reader; slave is its environment.
interface vreg_lane_reader_if #(
  parameter int unsigned N     = 24,
  parameter int unsigned LANES = 8,
  parameter int unsigned NREGS = 16
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned RW = $clog2(NREGS);

  logic          start;
  logic [RW-1:0] reg_sel;
  logic          busy;
  logic [RW-1:0] rd_reg;
  logic [LW-1:0] rd_lane;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  out_data;
  logic [LW-1:0] out_lane;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          done;

  modport master (
    input  start, reg_sel, rd_data, out_ready,
    output busy, rd_reg, rd_lane, out_data, out_lane, out_valid, out_last, done
  );

  modport slave (
    output start, reg_sel, rd_data, out_ready,
    input  busy, rd_reg, rd_lane, out_data, out_lane, out_valid, out_last, done
  );
endinterface

// File: rtl/vreg_lane_reader.sv
// Read-side streamer for the vector register bank. A start command latches a
// register index; every lane of that register is then read from the bank and
// emitted in order, one lane per beat, on a valid/ready stream. done pulses
// for one cycle after the last beat is accepted.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - command, bank read and output stream signals (master modport)
module vreg_lane_reader #(
  parameter int unsigned N     = 24,
  parameter int unsigned LANES = 8,
  parameter int unsigned NREGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  vreg_lane_reader_if.master  bus
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned RW = $clog2(NREGS);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] sel_q, sel_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [N-1:0]  data_q, data_d;
  logic [LW-1:0] olane_q, olane_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic slot_free;
  logic lane_is_last;

  // Output register can take a new beat when empty or being drained this cycle.
  assign slot_free    = !valid_q || bus.out_ready;
  assign lane_is_last = (lane_q == LW'(LANES - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lane_d  = lane_q;
    data_d  = data_q;
    olane_d = olane_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sel_d   = bus.reg_sel;
          lane_d  = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (slot_free) begin
          // Bank read is combinational on rd_reg/rd_lane, so capture it directly.
          data_d  = bus.rd_data;
          olane_d = lane_q;
          valid_d = 1'b1;
          last_d  = lane_is_last;
          if (lane_is_last) begin
            lane_d  = '0;
            state_d = StDrain;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      olane_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      olane_q <= olane_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.rd_reg    = sel_q;
  assign bus.rd_lane   = lane_q;
  assign bus.out_data  = data_q;
  assign bus.out_lane  = olane_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
